// File: rtl/pmem_responder.sv
// Line-granular memory responder: single-outstanding read/write requests served from an
// internal 256-bit line array after a fixed DELAY, with completion counters and a sticky error flag.
module pmem_responder #(
   parameter int unsigned INDEX_BITS = 10,
   parameter int unsigned DELAY      = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  pmem_address,
   input  logic         pmem_read,
   input  logic         pmem_write,
   input  logic [255:0] pmem_wdata,
   output logic [255:0] pmem_rdata,
   output logic         pmem_resp,
   output logic [31:0]  read_count,
   output logic [31:0]  write_count,
   output logic         proto_err
);

   localparam int unsigned LINES = 1 << INDEX_BITS;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [INDEX_BITS-1:0] idx_q, idx_d;
   logic                  op_wr_q, op_wr_d;
   logic [255:0]          wdata_q, wdata_d;
   logic [255:0]          rdata_q, rdata_d;
   logic                  resp_q, resp_d;
   logic [31:0]           read_count_q, read_count_d;
   logic [31:0]           write_count_q, write_count_d;
   logic                  err_q, err_d;

   logic [255:0]          mem [LINES];

   logic [INDEX_BITS-1:0] live_idx;
   logic                  req_live;
   logic                  enter_resp;
   logic [INDEX_BITS-1:0] commit_idx;
   logic                  commit_wr;
   logic [255:0]          commit_data;
   logic                  mem_we;
   logic                  unused_addr;

   assign live_idx    = pmem_address[INDEX_BITS+4:5];
   assign unused_addr = ^{pmem_address[31:INDEX_BITS+5], pmem_address[4:0]};

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         resp_q        <= 1'b0;
         rdata_q       <= '0;
         read_count_q  <= '0;
         write_count_q <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         resp_q        <= resp_d;
         rdata_q       <= rdata_d;
         read_count_q  <= read_count_d;
         write_count_q <= write_count_d;
         err_q         <= err_d;
      end
      idx_q   <= idx_d;
      op_wr_q <= op_wr_d;
      wdata_q <= wdata_d;
   end

   // Array is never reset; a commit is suppressed when rst lands on the same edge
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem[commit_idx] <= commit_data;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      op_wr_d  = op_wr_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      req_live = op_wr_q ? pmem_write : pmem_read;
      case (state_q)
         IDLE: begin
            if (pmem_read ^ pmem_write) begin
               idx_d   = live_idx;
               op_wr_d = pmem_write;
               wdata_d = pmem_wdata;
               cnt_d   = 8'(DELAY - 1);
               state_d = (DELAY == 1) ? RESP : BUSY;
            end else if (pmem_read && pmem_write) begin
               err_d = 1'b1;
            end
         end
         BUSY: begin
            if (!req_live) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
               if (cnt_q == 8'd1) state_d = RESP;
               if ((live_idx != idx_q) || (op_wr_q ? pmem_read : pmem_write) ||
                   (op_wr_q && (pmem_wdata != wdata_q))) begin
                  err_d = 1'b1;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs; with DELAY=1 RESP is entered straight from IDLE, so the live request is committed
   always_comb begin
      enter_resp    = (state_d == RESP) && (state_q != RESP);
      commit_idx    = (state_q == IDLE) ? live_idx   : idx_q;
      commit_wr     = (state_q == IDLE) ? pmem_write : op_wr_q;
      commit_data   = (state_q == IDLE) ? pmem_wdata : wdata_q;
      mem_we        = enter_resp && commit_wr;
      resp_d        = enter_resp;
      rdata_d       = rdata_q;
      read_count_d  = read_count_q;
      write_count_d = write_count_q;
      if (enter_resp && !commit_wr) rdata_d = mem[commit_idx];
      if (state_q == RESP) begin
         if (op_wr_q) write_count_d = write_count_q + 32'd1;
         else         read_count_d  = read_count_q + 32'd1;
      end
   end

   assign pmem_rdata  = rdata_q;
   assign pmem_resp   = resp_q;
   assign read_count  = read_count_q;
   assign write_count = write_count_q;
   assign proto_err   = err_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Bench for pmem_responder: a DELAY=10 instance and a DELAY=1 instance checked against a
// line-array/counter reference model.
module tb_pmem_responder;

   localparam int D = 10;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [31:0]  addr = '0;
   logic         rd = 1'b0, wr = 1'b0;
   logic [255:0] wdata = '0;
   logic [255:0] rdata;
   logic         resp, perr;
   logic [31:0]  rc, wc;

   logic [31:0]  addr1 = '0;
   logic         rd1 = 1'b0, wr1 = 1'b0;
   logic [255:0] wdata1 = '0;
   logic [255:0] rdata1;
   logic         resp1, perr1;
   logic [31:0]  rc1, wc1;

   int total = 0;
   int bad   = 0;

   logic [255:0] mem_m [int];
   int rcnt_m, wcnt_m, rcnt1_m, wcnt1_m;

   pmem_responder #(.INDEX_BITS(10), .DELAY(D)) dut (
      .clk(clk), .rst(rst), .pmem_address(addr), .pmem_read(rd), .pmem_write(wr),
      .pmem_wdata(wdata), .pmem_rdata(rdata), .pmem_resp(resp), .read_count(rc),
      .write_count(wc), .proto_err(perr));

   pmem_responder #(.INDEX_BITS(4), .DELAY(1)) dut1 (
      .clk(clk), .rst(rst), .pmem_address(addr1), .pmem_read(rd1), .pmem_write(wr1),
      .pmem_wdata(wdata1), .pmem_rdata(rdata1), .pmem_resp(resp1), .read_count(rc1),
      .write_count(wc1), .proto_err(perr1));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [255:0] rnd_line();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Drives one request on the DELAY=10 instance; lat counts edges from the drive point to resp.
   task automatic op(input bit is_wr, input logic [31:0] a, input logic [255:0] d, input bit b2b,
                     output logic [255:0] rdat, output int lat);
      addr = a; wdata = d; rd = !is_wr; wr = is_wr; lat = -1; rdat = 'x;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (resp) begin lat = c; rdat = rdata; break; end
      end
      if (!b2b) begin rd = 1'b0; wr = 1'b0; @(posedge clk); #1; end
   endtask

   task automatic op1(input bit is_wr, input logic [31:0] a, input logic [255:0] d,
                      output logic [255:0] rdat, output int lat);
      addr1 = a; wdata1 = d; rd1 = !is_wr; wr1 = is_wr; lat = -1; rdat = 'x;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (resp1) begin lat = c; rdat = rdata1; break; end
      end
      rd1 = 1'b0; wr1 = 1'b0; @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      rcnt_m = 0; wcnt_m = 0; rcnt1_m = 0; wcnt1_m = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1; repeat (3) @(posedge clk); #1;
      total++; if (resp !== 1'b0) begin bad++; $display("FAIL reset_resp: got %b want 0", resp); end
      total++; if (rdata !== '0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
      total++; if (rc !== 32'd0) begin bad++; $display("FAIL reset_rc: got %0d want 0", rc); end
      total++; if (wc !== 32'd0) begin bad++; $display("FAIL reset_wc: got %0d want 0", wc); end
      total++; if (perr !== 1'b0) begin bad++; $display("FAIL reset_perr: got %b want 0", perr); end
      total++; if (rc1 !== 32'd0 || resp1 !== 1'b0) begin bad++; $display("FAIL reset_dut1: rc %0d resp %b want 0 0", rc1, resp1); end
      rst = 1'b0;
      rcnt_m = 0; wcnt_m = 0; rcnt1_m = 0; wcnt1_m = 0;
   endtask

   task automatic test_write_read();
      logic [255:0] r, pat; int lat;
      pat = {32{8'hA5}};
      op(1'b1, 32'h0000_0040, pat, 1'b0, r, lat);
      mem_m[2] = pat; wcnt_m++;
      total++; if (lat !== D) begin bad++; $display("FAIL wr_latency: got %0d want %0d", lat, D); end
      op(1'b0, 32'h0000_005F, '0, 1'b0, r, lat);
      rcnt_m++;
      total++; if (lat !== D) begin bad++; $display("FAIL rd_latency: got %0d want %0d", lat, D); end
      total++; if (r !== pat) begin bad++; $display("FAIL rd_data: got %h want %h", r, pat); end
      total++; if (resp !== 1'b0) begin bad++; $display("FAIL resp_one_cycle: got %b want 0", resp); end
      total++; if (wc !== 32'd1 || rc !== 32'd1) begin bad++; $display("FAIL counts_wr_rd: got w%0d r%0d want w1 r1", wc, rc); end
   endtask

   task automatic test_back_to_back();
      logic [255:0] r, x, y; int lat;
      x = rnd_line(); y = rnd_line();
      op(1'b1, 32'(7 << 5), y, 1'b0, r, lat); mem_m[7] = y; wcnt_m++;
      op(1'b1, 32'(3 << 5), x, 1'b1, r, lat); mem_m[3] = x; wcnt_m++;
      total++; if (lat !== D) begin bad++; $display("FAIL b2b_wr_latency: got %0d want %0d", lat, D); end
      op(1'b0, 32'(3 << 5), '0, 1'b1, r, lat); rcnt_m++;
      total++; if (lat !== D + 1 || r !== x) begin bad++; $display("FAIL b2b_rd_same: lat %0d data %h want %0d %h", lat, r, D + 1, x); end
      op(1'b0, 32'(7 << 5), '0, 1'b0, r, lat); rcnt_m++;
      total++; if (lat !== D + 1 || r !== y) begin bad++; $display("FAIL b2b_rd_other: lat %0d data %h want %0d %h", lat, r, D + 1, y); end
      total++; if (wc !== 32'(wcnt_m) || rc !== 32'(rcnt_m)) begin bad++; $display("FAIL b2b_counts: got w%0d r%0d want w%0d r%0d", wc, rc, wcnt_m, rcnt_m); end
   endtask

   task automatic test_abort();
      logic [255:0] r, p; int lat; bit seen;
      p = rnd_line();
      op(1'b1, 32'(5 << 5), p, 1'b0, r, lat); mem_m[5] = p; wcnt_m++;
      addr = 32'(5 << 5); wdata = ~p; wr = 1'b1; seen = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         if (resp) seen = 1'b1;
         if (c == 4) wr = 1'b0;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_resp: got resp want none"); end
      op(1'b0, 32'(5 << 5), '0, 1'b0, r, lat); rcnt_m++;
      total++; if (lat !== D) begin bad++; $display("FAIL abort_next_latency: got %0d want %0d", lat, D); end
      total++; if (r !== p) begin bad++; $display("FAIL abort_data: got %h want %h", r, p); end
      total++; if (wc !== 32'(wcnt_m)) begin bad++; $display("FAIL abort_wc: got %0d want %0d", wc, wcnt_m); end
   endtask

   task automatic test_proto();
      logic [255:0] r, a, b; int lat;
      total++; if (perr !== 1'b0) begin bad++; $display("FAIL proto_pre: got %b want 0", perr); end
      rd = 1'b1; wr = 1'b1; addr = 32'(5 << 5);
      @(posedge clk); #1;
      total++; if (perr !== 1'b1 || resp !== 1'b0) begin bad++; $display("FAIL proto_both: perr %b resp %b want 1 0", perr, resp); end
      rd = 1'b0; wr = 1'b0;
      op(1'b0, 32'(5 << 5), '0, 1'b0, r, lat); rcnt_m++;
      total++; if (lat !== D || r !== mem_m[5]) begin bad++; $display("FAIL proto_stay_idle: lat %0d data %h want %0d %h", lat, r, D, mem_m[5]); end
      do_reset();
      total++; if (perr !== 1'b0) begin bad++; $display("FAIL proto_cleared: got %b want 0", perr); end
      a = rnd_line(); b = rnd_line();
      op(1'b1, 32'(10 << 5), a, 1'b0, r, lat); mem_m[10] = a; wcnt_m++;
      op(1'b1, 32'(11 << 5), b, 1'b0, r, lat); mem_m[11] = b; wcnt_m++;
      addr = 32'(10 << 5); rd = 1'b1; lat = -1; r = 'x;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (c == 3) begin
            total++; if (perr !== 1'b0) begin bad++; $display("FAIL proto_addr_early: got %b want 0", perr); end
            addr = 32'(11 << 5);
         end
         if (c == 4) begin
            total++; if (perr !== 1'b1) begin bad++; $display("FAIL proto_addr_flag: got %b want 1", perr); end
         end
         if (resp) begin lat = c; r = rdata; break; end
      end
      rd = 1'b0; @(posedge clk); #1; rcnt_m++;
      total++; if (lat !== D || r !== a) begin bad++; $display("FAIL proto_addr_resp: lat %0d data %h want %0d %h", lat, r, D, a); end
      do_reset();
   endtask

   task automatic test_reset_mid();
      logic [255:0] r, old; int lat; bit seen;
      old = rnd_line();
      op(1'b1, 32'(2 << 5), old, 1'b0, r, lat); mem_m[2] = old; wcnt_m++;
      op(1'b0, 32'(2 << 5), '0, 1'b0, r, lat); rcnt_m++;
      addr = 32'(2 << 5); wdata = ~old; wr = 1'b1; seen = 1'b0;
      for (int c = 1; c <= 5; c++) begin @(posedge clk); #1; if (resp) seen = 1'b1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; wr = 1'b0;
      rcnt_m = 0; wcnt_m = 0; rcnt1_m = 0; wcnt1_m = 0;
      total++; if (seen !== 1'b0 || resp !== 1'b0) begin bad++; $display("FAIL rstmid_resp: seen %b resp %b want 0 0", seen, resp); end
      total++; if (rdata !== '0) begin bad++; $display("FAIL rstmid_rdata: got %h want 0", rdata); end
      total++; if (rc !== 32'd0 || wc !== 32'd0 || perr !== 1'b0) begin bad++; $display("FAIL rstmid_regs: rc %0d wc %0d perr %b want 0 0 0", rc, wc, perr); end
      op(1'b0, 32'(2 << 5), '0, 1'b0, r, lat); rcnt_m++;
      total++; if (lat !== D || r !== old) begin bad++; $display("FAIL rstmid_kept: lat %0d data %h want %0d %h", lat, r, D, old); end
   endtask

   task automatic test_random();
      logic [255:0] r, d; logic [31:0] a; int lat, exp_lat; int unsigned idx; bit is_wr, b2b, prev_b2b;
      for (int unsigned i = 16; i < 24; i++) begin
         d = rnd_line();
         op(1'b1, 32'(i << 5), d, 1'b0, r, lat); mem_m[int'(i)] = d; wcnt_m++;
      end
      prev_b2b = 1'b0;
      for (int n = 0; n < 40; n++) begin
         is_wr = 1'($urandom % 2);
         b2b   = (n != 39) && ($urandom % 3 == 0);
         idx   = 16 + ($urandom % 8);
         a     = $urandom;
         a[14:5] = 10'(idx);
         d     = rnd_line();
         exp_lat = prev_b2b ? D + 1 : D;
         op(is_wr, a, d, b2b, r, lat);
         total++; if (lat !== exp_lat) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, exp_lat); end
         if (is_wr) begin
            mem_m[int'(idx)] = d; wcnt_m++;
         end else begin
            rcnt_m++;
            total++; if (r !== mem_m[int'(idx)]) begin bad++; $display("FAIL rand_data[%0d]: got %h want %h", n, r, mem_m[int'(idx)]); end
         end
         prev_b2b = b2b;
      end
      total++; if (rc !== 32'(rcnt_m) || wc !== 32'(wcnt_m)) begin bad++; $display("FAIL rand_counts: got r%0d w%0d want r%0d w%0d", rc, wc, rcnt_m, wcnt_m); end
   endtask

   task automatic test_delay1();
      logic [255:0] r, d; int lat; logic [9:0] seen_pat;
      d = rnd_line();
      op1(1'b1, 32'(1 << 5), d, r, lat); wcnt1_m++;
      total++; if (lat !== 1) begin bad++; $display("FAIL d1_wr_latency: got %0d want 1", lat); end
      op1(1'b0, 32'(1 << 5), '0, r, lat); rcnt1_m++;
      total++; if (lat !== 1 || r !== d) begin bad++; $display("FAIL d1_rd: lat %0d data %h want 1 %h", lat, r, d); end
      addr1 = 32'(1 << 5); rd1 = 1'b1; seen_pat = '0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         seen_pat[c-1] = resp1;
      end
      rd1 = 1'b0; rcnt1_m += 5;
      @(posedge clk); #1;
      total++; if (seen_pat !== 10'b01_0101_0101) begin bad++; $display("FAIL d1_held_pattern: got %b want 0101010101", seen_pat); end
      total++; if (rc1 !== 32'(rcnt1_m) || wc1 !== 32'(wcnt1_m)) begin bad++; $display("FAIL d1_counts: got r%0d w%0d want r%0d w%0d", rc1, wc1, rcnt1_m, wcnt1_m); end
   endtask

   task automatic test_wrap();
      logic [255:0] r; int lat;
      force dut1.read_count_q = 32'hFFFF_FFFF;
      #1;
      release dut1.read_count_q;
      @(posedge clk); #1;
      total++; if (rc1 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_preset: got %h want ffffffff", rc1); end
      op1(1'b0, 32'(1 << 5), '0, r, lat);
      total++; if (rc1 !== 32'd0 || wc1 !== 32'(wcnt1_m)) begin bad++; $display("FAIL wrap_count: got r%h w%0d want r0 w%0d", rc1, wc1, wcnt1_m); end
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_abort();
      test_proto();
      test_reset_mid();
      test_random();
      test_delay1();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
